// File: rtl/lif_timestep_scheduler.sv
// Sequences N_NEURONS virtual LIF neurons through one shared update datapath.
// Latency: 2*N_NEURONS+1 cycles per tick; no backpressure, ticks while busy are dropped and flagged sticky in overrun.
module lif_timestep_scheduler #(
    parameter int N_NEURONS = 8,
    parameter int W         = 8,
    parameter int IW        = $clog2(N_NEURONS),
    parameter int RW        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [W-1:0]         threshold,
    input  logic [2:0]           leak_shift,
    input  logic [RW-1:0]        refr_period,
    output logic                 cur_req,
    output logic [IW-1:0]        cur_idx,
    input  logic [W-1:0]         cur_in,
    output logic                 spike_valid,
    output logic [IW-1:0]        spike_idx,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic                 done,
    output logic                 busy,
    output logic                 overrun,
    input  logic [IW-1:0]        mem_rd_idx,
    output logic [W-1:0]         mem_rd_data
);

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N_NEURONS-1:0]   acc_q, acc_d;
    logic [N_NEURONS-1:0]   spike_vec_q;
    logic [W-1:0]           cur_q;
    logic [W-1:0]           thr_q;
    logic [2:0]             leak_q;
    logic [RW-1:0]          refp_q;
    logic                   spike_valid_q;
    logic [IW-1:0]          spike_idx_q;
    logic                   overrun_q;
    logic [W-1:0]           mem_q  [N_NEURONS];
    logic [RW-1:0]          refr_q [N_NEURONS];

    logic [W-1:0]           mem_cur;
    logic [RW-1:0]          refr_cur;
    logic [W-1:0]           leak_amt;
    logic [W:0]             sum;
    logic [W-1:0]           sat;
    logic                   in_refr;
    logic                   fire;
    logic [W-1:0]           new_mem;
    logic [RW-1:0]          new_refr;

    // Shared datapath for the neuron currently addressed by idx_q.
    always_comb begin
        mem_cur  = mem_q[idx_q];
        refr_cur = refr_q[idx_q];
        in_refr  = (refr_cur != '0);
        leak_amt = (leak_q == 3'd0) ? '0 : (mem_cur >> leak_q);
        sum      = {1'b0, mem_cur - leak_amt} + {1'b0, cur_q};
        sat      = sum[W] ? {W{1'b1}} : sum[W-1:0];
        fire     = !in_refr && (sat >= thr_q);
        new_mem  = (in_refr || fire) ? '0 : sat;
        if (in_refr) begin
            new_refr = refr_cur - 1'b1;
        end else if (fire) begin
            new_refr = refp_q;
        end else begin
            new_refr = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = FETCH;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            FETCH: begin
                state_d = UPDATE;
            end
            UPDATE: begin
                acc_d[idx_q] = acc_q[idx_q] | fire;
                if (idx_q == IW'(N_NEURONS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            spike_vec_q   <= '0;
            cur_q         <= '0;
            thr_q         <= '0;
            leak_q        <= '0;
            refp_q        <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            if (state_q == IDLE && tick) begin
                thr_q  <= threshold;
                leak_q <= leak_shift;
                refp_q <= refr_period;
            end
            if (state_q == FETCH) begin
                cur_q <= cur_in;
            end
            if (state_q == DONE) begin
                spike_vec_q <= acc_q;
            end
            spike_valid_q <= (state_q == UPDATE) && fire;
            spike_idx_q   <= ((state_q == UPDATE) && fire) ? idx_q : '0;
            if (tick && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i]  <= '0;
                refr_q[i] <= '0;
            end
        end else if (state_q == UPDATE) begin
            mem_q[idx_q]  <= new_mem;
            refr_q[idx_q] <= new_refr;
        end
    end

    assign cur_req     = (state_q == FETCH);
    assign cur_idx     = idx_q;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign spike_vec   = spike_vec_q;
    assign done        = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign mem_rd_data = mem_q[mem_rd_idx];

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Directed bench for lif_timestep_scheduler with hand-computed expectations.
module tb_lif_timestep_scheduler;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int IW = 3;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [W-1:0]  threshold;
    logic [2:0]    leak_shift;
    logic [RW-1:0] refr_period;
    logic          cur_req;
    logic [IW-1:0] cur_idx;
    logic [W-1:0]  cur_in;
    logic          spike_valid;
    logic [IW-1:0] spike_idx;
    logic [N-1:0]  spike_vec;
    logic          done;
    logic          busy;
    logic          overrun;
    logic [IW-1:0] mem_rd_idx;
    logic [W-1:0]  mem_rd_data;

    lif_timestep_scheduler #(.N_NEURONS(N), .W(W), .RW(RW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .threshold(threshold),
        .leak_shift(leak_shift), .refr_period(refr_period),
        .cur_req(cur_req), .cur_idx(cur_idx), .cur_in(cur_in),
        .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_vec(spike_vec),
        .done(done), .busy(busy), .overrun(overrun),
        .mem_rd_idx(mem_rd_idx), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] cur_tab [N];
    logic [7:0] spikes_seen;
    int         done_cnt;
    int         done_cyc;
    int         seq_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_cur(input int i, input logic [7:0] v);
        for (int k = 0; k < N; k++) cur_tab[k] = 8'd0;
        cur_tab[i] = v;
    endtask

    // One timestep; tick held for 'hold' sampled edges. Cycle 1 is the first FETCH.
    task automatic run_tick(input string tag, input int hold);
        logic exp_req;
        spikes_seen = '0;
        done_cnt    = 0;
        done_cyc    = 0;
        seq_err     = 0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 20; c++) begin
            if (c >= hold) tick = 1'b0;
            exp_req = (c % 2 == 1) && (c <= 15);
            if (cur_req !== exp_req) seq_err++;
            if (exp_req && cur_idx !== IW'((c - 1) / 2)) seq_err++;
            if (busy !== (c <= 17)) seq_err++;
            cur_in = cur_req ? cur_tab[cur_idx] : 8'd0;
            if (spike_valid) spikes_seen[spike_idx] = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            @(negedge clk);
        end
        check({tag, " done_cnt"}, done_cnt, 1);
        check({tag, " done_cyc"}, done_cyc, 17);
    endtask

    task automatic read_mem(input int i, output logic [7:0] v);
        mem_rd_idx = IW'(i);
        #1;
        v = mem_rd_data;
    endtask

    logic [7:0] rv;
    int         nz;

    initial begin
        rst = 1'b1; tick = 1'b0; threshold = '0; leak_shift = '0; refr_period = '0;
        cur_in = '0; mem_rd_idx = '0;
        for (int k = 0; k < N; k++) cur_tab[k] = 8'd0;
        #12;
        check("rst busy", busy, 0);
        check("rst cur_req", cur_req, 0);
        check("rst outputs", {spike_valid, spike_idx, spike_vec, done, overrun, cur_idx}, 0);
        rst = 1'b0;

        // Reset mid-timestep, during the FETCH of neuron 3.
        threshold = 8'd255;
        for (int k = 0; k < N; k++) cur_tab[k] = 8'd5;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        for (int c = 1; c < 7; c++) begin
            cur_in = cur_req ? cur_tab[cur_idx] : 8'd0;
            @(negedge clk);
        end
        check("pre-reset cur_idx", cur_idx, 3);
        read_mem(1, rv);
        check("pre-reset mem1", rv, 5);
        rst = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst outputs", {cur_req, spike_valid, spike_idx, spike_vec, done, overrun, cur_idx}, 0);
        nz = 0;
        for (int k = 0; k < N; k++) begin
            read_mem(k, rv);
            if (rv != 0) nz++;
        end
        check("midrst mem nonzero", nz, 0);
        @(negedge clk);
        rst = 1'b0;
        run_tick("post-rst", 1);
        check("post-rst seq", seq_err, 0);
        read_mem(7, rv);
        check("post-rst mem7", rv, 5);

        // Integrate and fire.
        do_reset();
        threshold = 8'd100; leak_shift = 3'd0; refr_period = 4'd0;
        set_cur(0, 8'd30);
        for (int t = 1; t <= 3; t++) begin
            run_tick("int", 1);
            read_mem(0, rv);
            check("int mem0", rv, 8'(30 * t));
            check("int nospike", spikes_seen, 0);
        end
        run_tick("int4", 1);
        check("int4 spike", spikes_seen, 8'h01);
        read_mem(0, rv);
        check("int4 mem0", rv, 0);
        check("int4 vec", spike_vec, 8'h01);

        // Leak.
        do_reset();
        threshold = 8'd255; leak_shift = 3'd0;
        set_cur(0, 8'd64);
        run_tick("leak0", 1);
        read_mem(0, rv);
        check("leak mem 64", rv, 64);
        set_cur(0, 8'd0);
        leak_shift = 3'd1;
        run_tick("leak1", 1);
        read_mem(0, rv);
        check("leak mem 32", rv, 32);
        run_tick("leak2", 1);
        read_mem(0, rv);
        check("leak mem 16", rv, 16);
        leak_shift = 3'd0;
        run_tick("leak3", 1);
        read_mem(0, rv);
        check("leak hold 16", rv, 16);

        // Saturation.
        do_reset();
        threshold = 8'd255; leak_shift = 3'd0;
        set_cur(5, 8'd200);
        run_tick("sat1", 1);
        read_mem(5, rv);
        check("sat mem5 200", rv, 200);
        check("sat1 vec", spike_vec, 0);
        run_tick("sat2", 1);
        check("sat2 spike", spikes_seen, 8'h20);
        check("sat2 vec", spike_vec, 8'h20);
        read_mem(5, rv);
        check("sat2 mem5", rv, 0);

        // Refractory.
        do_reset();
        threshold = 8'd10; refr_period = 4'd2;
        set_cur(2, 8'd20);
        run_tick("refr1", 1);
        check("refr1 vec", spike_vec, 8'h04);
        run_tick("refr2", 1);
        check("refr2 vec", spike_vec, 8'h00);
        read_mem(2, rv);
        check("refr2 mem2", rv, 0);
        run_tick("refr3", 1);
        check("refr3 spikes", spikes_seen, 8'h00);
        read_mem(2, rv);
        check("refr3 mem2", rv, 0);
        run_tick("refr4", 1);
        check("refr4 vec", spike_vec, 8'h04);

        // Threshold zero: every neuron fires; config change mid-step is ignored.
        do_reset();
        threshold = 8'd0; refr_period = 4'd0;
        set_cur(0, 8'd0);
        fork
            run_tick("thr0", 1);
            begin
                repeat (4) @(negedge clk);
                threshold = 8'd200;
            end
        join
        check("thr0 vec", spike_vec, 8'hFF);
        check("thr0 spikes", spikes_seen, 8'hFF);

        // Overrun and timing.
        do_reset();
        threshold = 8'd255;
        check("ovr init", overrun, 0);
        run_tick("ovr", 3);
        check("ovr seq", seq_err, 0);
        check("ovr set", overrun, 1);
        run_tick("ovr2", 1);
        check("ovr sticky", overrun, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
